alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: requester 0 is the main pipeline execute stage and requester 1 is the branch/compare unit. Each cycle at most one eligible request is granted and driven onto the ALU inputs. The ALU result and zero flag are captured into that requester's response register. Each requester sees a registered response with a valid/ready handshake.

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/alu_arb_grant.sv | 37 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared ALU arbiter types: ALU op codes, response slot states, requester ids.
// Used by alu_arbiter and alu_arb_grant.
package alu_arb_pkg;

   localparam int NUM_REQ = 2;
   localparam int REQ_EXE = 0;
   localparam int REQ_BRU = 1;

   typedef enum logic [3:0] {
      ALU_AND     = 4'b0000,
      ALU_OR      = 4'b0001,
      ALU_NOR     = 4'b0010,
      ALU_ADD     = 4'b0011,
      ALU_SUB     = 4'b0100,
      ALU_LUI     = 4'b0101,
      ALU_SLL     = 4'b0111,
      ALU_SRL     = 4'b1000,
      ALU_BNE     = 4'b1001,
      ALU_NOP_BEQ = 4'b1111
   } alu_op_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way grant logic for the shared ALU; round-robin by default,
// fixed priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_grant
   import alu_arb_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] eligible,
   output logic [NUM_REQ-1:0] grant
);

   // High means requester 1 was served last, so requester 0 wins next tie.
   logic last_grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign last_grant = 1'b1;
`else
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[REQ_BRU];
      end
   end
`endif

   always_comb begin
      grant = '0;
      unique case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between execute (0) and branch unit (1).
// Priority mode selected by ALU_ARB_FIXED_PRIO_EN (default round-robin).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   input  logic [3:0]            req_op0,
   input  logic [3:0]            req_op1,
   input  logic [DATA_WIDTH-1:0] req_a0,
   input  logic [DATA_WIDTH-1:0] req_a1,
   input  logic [DATA_WIDTH-1:0] req_b0,
   input  logic [DATA_WIDTH-1:0] req_b1,
   input  logic [4:0]            req_shamt0,
   input  logic [4:0]            req_shamt1,
   output logic [1:0]            req_ready,
   output logic [3:0]            alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [4:0]            alu_shamt,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic [1:0]            rsp_valid,
   input  logic [1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result0,
   output logic [DATA_WIDTH-1:0] rsp_result1,
   output logic [1:0]            rsp_zero
);

   logic [NUM_REQ-1:0] full;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;

   // A full slot may accept a new result only if it drains this cycle.
   // Gating with reset keeps the ALU idle and blocks grants during reset.
   assign eligible = req_valid
                   & (~full | rsp_ready)
                   & {NUM_REQ{reset}};

   alu_arb_grant u_grant (
      .clk      (clk),
      .reset    (reset),
      .eligible (eligible),
      .grant    (grant)
   );

   assign req_ready = grant;

   always_comb begin
      alu_op    = ALU_NOP_BEQ;
      alu_a     = '0;
      alu_b     = '0;
      alu_shamt = '0;
      unique case (1'b1)
         grant[REQ_EXE]: begin
            alu_op    = req_op0;
            alu_a     = req_a0;
            alu_b     = req_b0;
            alu_shamt = req_shamt0;
         end
         grant[REQ_BRU]: begin
            alu_op    = req_op1;
            alu_a     = req_a1;
            alu_b     = req_b1;
            alu_shamt = req_shamt1;
         end
         default: begin
            alu_op    = ALU_NOP_BEQ;
            alu_a     = '0;
            alu_b     = '0;
            alu_shamt = '0;
         end
      endcase
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      slot_e                 state_q;
      slot_e                 state_d;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  zero_q;

      always_ff @(posedge clk) begin
         if (!reset) begin
            state_q <= SLOT_EMPTY;
         end else begin
            state_q <= state_d;
         end
      end

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            SLOT_EMPTY: begin
               if (grant[i]) begin
                  state_d = SLOT_FULL;
               end
            end
            SLOT_FULL: begin
               if (rsp_ready[i] && !grant[i]) begin
                  state_d = SLOT_EMPTY;
               end
            end
            default: state_d = SLOT_EMPTY;
         endcase
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            data_q <= '0;
            zero_q <= 1'b0;
         end else if (grant[i]) begin
            data_q <= alu_result;
            zero_q <= alu_zero;
         end
      end

      assign full[i]      = (state_q == SLOT_FULL);
      assign rsp_valid[i] = full[i];
      assign rsp_zero[i]  = zero_q;
   end

   assign rsp_result0 = g_slot[REQ_EXE].data_q;
   assign rsp_result1 = g_slot[REQ_BRU].data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU.
// Expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int DW = 32;

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req_valid;
   logic [3:0]    req_op0, req_op1;
   logic [DW-1:0] req_a0, req_a1, req_b0, req_b1;
   logic [4:0]    req_shamt0, req_shamt1;
   logic [1:0]    req_ready;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu_a, alu_b;
   logic [4:0]    alu_shamt;
   logic [DW-1:0] alu_result;
   logic          alu_zero;
   logic [1:0]    rsp_valid;
   logic [1:0]    rsp_ready;
   logic [DW-1:0] rsp_result0, rsp_result1;
   logic [1:0]    rsp_zero;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_op0     (req_op0),
      .req_op1     (req_op1),
      .req_a0      (req_a0),
      .req_a1      (req_a1),
      .req_b0      (req_b0),
      .req_b1      (req_b1),
      .req_shamt0  (req_shamt0),
      .req_shamt1  (req_shamt1),
      .req_ready   (req_ready),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_shamt   (alu_shamt),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result0 (rsp_result0),
      .rsp_result1 (rsp_result1),
      .rsp_zero    (rsp_zero)
   );

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_AND: alu_result = alu_a & alu_b;
         ALU_OR:  alu_result = alu_a | alu_b;
         ALU_NOR: alu_result = ~(alu_a | alu_b);
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_LUI: alu_result = alu_b << 16;
         ALU_SLL: alu_result = alu_a << alu_shamt;
         ALU_SRL: alu_result = alu_a >> alu_shamt;
         ALU_BNE: alu_result = alu_a ^ alu_b;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   task automatic check(input string tag,
                        input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      req_valid = 2'b00;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      logic [1:0] exp2;

      reset      = 1'b0;
      req_valid  = 2'b11;
      req_op0    = ALU_NOP_BEQ;
      req_op1    = ALU_NOP_BEQ;
      req_a0     = 32'd0;
      req_a1     = 32'd0;
      req_b0     = 32'd0;
      req_b1     = 32'd0;
      req_shamt0 = 5'd0;
      req_shamt1 = 5'd0;
      rsp_ready  = 2'b00;

      #4;
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_op", 32'(alu_op), 32'hf);
      tick();
      check("rst_valid", 32'(rsp_valid), 32'h0);
      check("rst_res0", rsp_result0, 32'h0);
      check("rst_res1", rsp_result1, 32'h0);
      check("rst_zero", 32'(rsp_zero), 32'h0);
      tick();

      // single requester ADD
      reset     = 1'b1;
      req_valid = 2'b01;
      req_op0   = ALU_ADD;
      req_a0    = 32'd5;
      req_b0    = 32'd7;
      rsp_ready = 2'b11;
      #3;
      check("add_ready", 32'(req_ready), 32'h1);
      check("add_op", 32'(alu_op), 32'h3);
      check("add_a", alu_a, 32'd5);
      check("add_b", alu_b, 32'd7);
      tick();
      check("add_valid", 32'(rsp_valid), 32'h1);
      check("add_res", rsp_result0, 32'd12);
      check("add_zero", 32'(rsp_zero), 32'h0);

      // shift passes shamt through; full slot draining accepts again
      req_op0    = ALU_SLL;
      req_a0     = 32'd3;
      req_b0     = 32'd0;
      req_shamt0 = 5'd4;
      #3;
      check("sll_ready", 32'(req_ready), 32'h1);
      check("sll_shamt", 32'(alu_shamt), 32'h4);
      tick();
      check("sll_valid", 32'(rsp_valid), 32'h1);
      check("sll_res", rsp_result0, 32'd48);

      // idle
      req_valid = 2'b00;
      #3;
      check("idle_ready", 32'(req_ready), 32'h0);
      check("idle_op", 32'(alu_op), 32'hf);
      check("idle_a", alu_a, 32'h0);
      check("idle_b", alu_b, 32'h0);
      check("idle_shamt", 32'(alu_shamt), 32'h0);
      tick();
      check("idle_valid", 32'(rsp_valid), 32'h0);
      check("idle_res0", rsp_result0, 32'd48);

      // both requesters contend every cycle
      apply_reset();
      req_valid  = 2'b11;
      req_op0    = ALU_ADD;
      req_a0     = 32'd1;
      req_b0     = 32'd2;
      req_shamt0 = 5'd0;
      req_op1    = ALU_OR;
      req_a1     = 32'd4;
      req_b1     = 32'd8;
      rsp_ready  = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp2 = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
         #3;
         check("rr_ready", 32'(req_ready), 32'(exp2));
         tick();
         check("rr_valid", 32'(rsp_valid), 32'(exp2));
         if (exp2[0]) check("rr_res0", rsp_result0, 32'd3);
         else         check("rr_res1", rsp_result1, 32'd12);
      end

      // back-pressure on requester 1
      apply_reset();
      req_valid = 2'b10;
      req_op1   = ALU_SUB;
      req_a1    = 32'd9;
      req_b1    = 32'd9;
      rsp_ready = 2'b00;
      #3;
      check("bp_first", 32'(req_ready), 32'h2);
      tick();
      check("bp_res1", rsp_result1, 32'h0);
      check("bp_zero", 32'(rsp_zero), 32'h2);
      req_valid = 2'b11;
      rsp_ready = 2'b01;
      req_op0   = ALU_ADD;
      req_b0    = 32'd1;
      for (int k = 0; k < 3; k++) begin
         req_a0 = 32'(100 + k);
         #3;
         check("bp_ready", 32'(req_ready), 32'h1);
         tick();
         check("bp_valid", 32'(rsp_valid), 32'h3);
         check("bp_res0", rsp_result0, 32'(101 + k));
         check("bp_hold1", rsp_result1, 32'h0);
         check("bp_hzero", 32'(rsp_zero), 32'h2);
      end
      rsp_ready = 2'b11;
      req_a1    = 32'd9;
      req_b1    = 32'd4;
      #3;
      check("bp_release", 32'(req_ready), FIXED ? 32'h1 : 32'h2);
      tick();
      check("bp_rvalid", 32'(rsp_valid), FIXED ? 32'h1 : 32'h2);
      check("bp_rres1", rsp_result1, FIXED ? 32'd0 : 32'd5);
      check("bp_rzero", 32'(rsp_zero), FIXED ? 32'h2 : 32'h0);

      // reset with both slots full
      apply_reset();
      req_valid = 2'b11;
      req_op0   = ALU_ADD;
      req_a0    = 32'd1;
      req_b0    = 32'd1;
      req_op1   = ALU_OR;
      req_a1    = 32'd6;
      req_b1    = 32'd0;
      rsp_ready = 2'b00;
      #3;
      check("fr_g0", 32'(req_ready), 32'h1);
      tick();
      #3;
      check("fr_g1", 32'(req_ready), 32'h2);
      tick();
      check("fr_full", 32'(rsp_valid), 32'h3);
      check("fr_res1", rsp_result1, 32'd6);
      reset = 1'b0;
      #3;
      check("fr_rst_rdy", 32'(req_ready), 32'h0);
      tick();
      check("fr_valid", 32'(rsp_valid), 32'h0);
      check("fr_res0", rsp_result0, 32'h0);
      check("fr_res1c", rsp_result1, 32'h0);
      reset = 1'b1;
      #3;
      check("fr_first", 32'(req_ready), 32'h1);
      tick();
      check("fr_after", 32'(rsp_valid), 32'h1);
      check("fr_newres", rsp_result0, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
